// File: rtl/sdram_dq_arbiter.sv
// Round-robin owner of the shared SDRAM DQ bus: write bursts from the frame
// loader, read bursts for TFT scan-out, with read->write turnaround.
module sdram_dq_arbiter #(
  parameter int WIDTH   = 16,
  parameter int BURST   = 8,
  parameter int CAS_LAT = 2,
  parameter int TURN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  output logic             wr_gnt,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_data_ack,
  input  logic             rd_req,
  output logic             rd_gnt,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             cmd_wr,
  output logic             cmd_rd,
  output logic             dq_oe,
  output logic [WIDTH-1:0] dq_out,
  input  logic [WIDTH-1:0] dq_in,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_WRITE,
    S_READ
  } state_t;

  localparam logic [7:0] BL = 8'(BURST);
  localparam logic [7:0] CL = 8'(CAS_LAT);
  localparam logic [7:0] TL = 8'(TURN);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_wr_q, last_wr_d;
  logic             dir_wr_q, dir_wr_d;
  logic             rd_wait_q, rd_wait_d;
  logic             wr_gnt_d, rd_gnt_d;
  logic             rd_valid_d, cmd_wr_d, cmd_rd_d;
  logic             dq_oe_d;
  logic [WIDTH-1:0] rd_data_d, dq_out_d;
  logic             pick_rd;

  // Read wins a tie unless it was the last one served.
  assign pick_rd = rd_req && (!wr_req || last_wr_q);
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    last_wr_d   = last_wr_q;
    dir_wr_d    = dir_wr_q;
    rd_wait_d   = rd_wait_q;
    wr_gnt_d    = wr_gnt;
    rd_gnt_d    = rd_gnt;
    rd_valid_d  = 1'b0;
    cmd_wr_d    = 1'b0;
    cmd_rd_d    = 1'b0;
    dq_oe_d     = dq_oe;
    rd_data_d   = rd_data;
    dq_out_d    = dq_out;
    wr_data_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (pick_rd) begin
          state_d   = S_READ;
          rd_gnt_d  = 1'b1;
          cmd_rd_d  = 1'b1;
          rd_wait_d = 1'b1;
        end else if (wr_req) begin
          wr_gnt_d = 1'b1;
          state_d  = dir_wr_q ? S_WRITE : S_TURN;
        end
      end
      S_TURN: begin
        dq_oe_d = 1'b0;
        if (cnt_q == TL - 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q < BL) begin
          wr_data_ack = 1'b1;
          dq_out_d    = wr_data;
          dq_oe_d     = 1'b1;
          cmd_wr_d    = (cnt_q == 8'd0);
        end else begin
          dq_oe_d   = 1'b0;
          wr_gnt_d  = 1'b0;
          dir_wr_d  = 1'b1;
          last_wr_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
        end
      end
      S_READ: begin
        dq_oe_d = 1'b0;
        // Wait out CAS latency, then count captured words.
        if (rd_wait_q) begin
          if (cnt_q == CL - 8'd1) begin
            cnt_d     = 8'd0;
            rd_wait_d = 1'b0;
          end
        end else if (cnt_q < BL) begin
          rd_data_d  = dq_in;
          rd_valid_d = 1'b1;
        end else begin
          rd_gnt_d  = 1'b0;
          dir_wr_d  = 1'b0;
          last_wr_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      last_wr_q <= 1'b1;
      dir_wr_q  <= 1'b0;
      rd_wait_q <= 1'b0;
      wr_gnt    <= 1'b0;
      rd_gnt    <= 1'b0;
      rd_valid  <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      dq_oe     <= 1'b0;
      rd_data   <= '0;
      dq_out    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      dir_wr_q  <= dir_wr_d;
      rd_wait_q <= rd_wait_d;
      wr_gnt    <= wr_gnt_d;
      rd_gnt    <= rd_gnt_d;
      rd_valid  <= rd_valid_d;
      cmd_wr    <= cmd_wr_d;
      cmd_rd    <= cmd_rd_d;
      dq_oe     <= dq_oe_d;
      rd_data   <= rd_data_d;
      dq_out    <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_sdram_dq_arbiter.sv
// Directed bench for sdram_dq_arbiter: SDRAM responder model plus
// write/read data scoreboards and a round-robin grant model.
module tb_sdram_dq_arbiter;
  localparam int W = 16;
  localparam int B = 8;
  localparam int T = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wr_req = 1'b0, rd_req = 1'b0, sel3 = 1'b0;
  logic [W-1:0] wr_data = '0, dq_in = '0;

  logic wg2, wa2, rg2, rv2, cw2, cr2, oe2, bz2;
  logic wg3, wa3, rg3, rv3, cw3, cr3, oe3, bz3;
  logic [W-1:0] rdd2, dqo2, rdd3, dqo3;
  logic wg, wa, rg, rv, cw, cr, oe, bz;
  logic [W-1:0] rdd, dqo;

  sdram_dq_arbiter #(.WIDTH(W), .BURST(B), .CAS_LAT(2), .TURN(T)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req & ~sel3), .wr_gnt(wg2),
    .wr_data(wr_data), .wr_data_ack(wa2),
    .rd_req(rd_req & ~sel3), .rd_gnt(rg2),
    .rd_data(rdd2), .rd_valid(rv2),
    .cmd_wr(cw2), .cmd_rd(cr2),
    .dq_oe(oe2), .dq_out(dqo2), .dq_in(dq_in),
    .busy(bz2)
  );

  sdram_dq_arbiter #(.WIDTH(W), .BURST(B), .CAS_LAT(3), .TURN(T)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req & sel3), .wr_gnt(wg3),
    .wr_data(wr_data), .wr_data_ack(wa3),
    .rd_req(rd_req & sel3), .rd_gnt(rg3),
    .rd_data(rdd3), .rd_valid(rv3),
    .cmd_wr(cw3), .cmd_rd(cr3),
    .dq_oe(oe3), .dq_out(dqo3), .dq_in(dq_in),
    .busy(bz3)
  );

  assign wg  = sel3 ? wg3 : wg2;
  assign wa  = sel3 ? wa3 : wa2;
  assign rg  = sel3 ? rg3 : rg2;
  assign rv  = sel3 ? rv3 : rv2;
  assign cw  = sel3 ? cw3 : cw2;
  assign cr  = sel3 ? cr3 : cr2;
  assign oe  = sel3 ? oe3 : oe2;
  assign bz  = sel3 ? bz3 : bz2;
  assign rdd = sel3 ? rdd3 : rdd2;
  assign dqo = sel3 ? dqo3 : dqo2;

  int errors = 0, checks = 0, cyc_n = 0, cas = 2;
  logic [W-1:0] wq[$];
  logic [W-1:0] rq[$];
  bit last_w, dir_r, pwr, prd, pwg, prg, ack_prev, rd_act;
  int wacks, gap, rvals, rcmd, rd_t;
  int gcount = 0, wbursts = 0, rbursts = 0;
  bit [15:0] gbits = '0;
  logic [W-1:0] rbase = '0, wfirst = '0, cmdwr_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_w = 1'b1; dir_r = 1'b1;
    pwg = 1'b0; prg = 1'b0; ack_prev = 1'b0; rd_act = 1'b0;
    wq.delete(); rq.delete();
    wacks = 0; gap = 0; rvals = 0; rd_t = 0;
    dq_in = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    chk("gnt_excl", 32'(wg & rg), 0);
    chk("oe_vs_rd_gnt", 32'(oe & rg), 0);
    chk("busy", 32'(bz), 32'(wg | rg));
    if ((wg & !pwg) | (rg & !prg)) begin
      chk("grant_order", 32'(rg), 32'(prd & (!pwr | last_w)));
      last_w = !rg;
      gbits[gcount % 16] = rg;
      gcount++;
      if (rg) begin
        chk("cmd_rd_first", 32'(cr), 1);
        rcmd = cyc_n; rvals = 0;
      end else begin
        wacks = 0; gap = 0;
      end
    end
    if (oe) begin
      if (wq.size() == 0) chk("dq_oe_extra", 32'(oe), 0);
      else chk("dq_out", 32'(dqo), 32'(wq.pop_front()));
    end
    if (cw) begin
      chk("cmd_wr_oe", 32'(oe), 1);
      chk("cmd_wr_word", 32'(dqo), 32'(wfirst));
      cmdwr_word = dqo;
    end
    if (wg && !wa && wacks == 0) begin
      chk("turn_oe", 32'(oe), 0);
      gap++;
    end
    if (wa) begin
      if (wacks == 0) begin
        chk("turn_gap", gap, dir_r ? T : 0);
        wfirst = wr_data;
      end
      wacks++;
      wq.push_back(wr_data);
    end
    if (!wg && pwg) begin
      chk("wr_ack_count", wacks, B);
      dir_r = 1'b0; wbursts++;
    end
    if (rv) begin
      if (rvals == 0) chk("rd_latency", cyc_n - rcmd, cas + 1);
      rvals++;
      if (rq.size() == 0) chk("rd_valid_extra", 32'(rv), 0);
      else chk("rd_data", 32'(rdd), 32'(rq.pop_front()));
    end
    if (!rg && prg) begin
      chk("rd_valid_count", rvals, B);
      dir_r = 1'b1; rbursts++;
    end
    if (cr) begin rd_act = 1'b1; rd_t = 0; end
    pwg = wg; prg = rg; pwr = wr_req; prd = rd_req; ack_prev = wa;
    @(posedge clk);
    #1;
    if (ack_prev) wr_data = wr_data + 16'd1;
    if (rd_act) begin
      rd_t++;
      if (rd_t >= cas && rd_t < cas + B) begin
        dq_in = rbase + 16'(rd_t - cas);
        rq.push_back(dq_in);
      end else begin
        dq_in = 16'hDEAD;
        if (rd_t >= cas + B) rd_act = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grant();
    int target, n;
    target = gcount + 1;
    n = 0;
    while (gcount < target && n < 40) begin
      tick();
      n++;
    end
    chk("grant_timeout", 32'(gcount >= target), 1);
  endtask

  initial begin
    int n, r0;
    model_reset();
    // reset with both requests pending
    wr_req = 1'b1; rd_req = 1'b1;
    rbase = 16'h2000; wr_data = 16'h0100;
    run(2);
    chk("rst_ctrl", 32'({wg, wa, rg, rv, cw, cr, oe, bz}), 0);
    chk("rst_dq_out", 32'(dqo), 0);
    chk("rst_rd_data", 32'(rdd), 0);
    rst_n = 1'b1;
    // six back-to-back bursts, read first, alternating
    n = 0;
    while (gcount < 6 && n < 200) begin
      tick();
      n++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("six_grants", 32'(gcount >= 6), 1);
    chk("alt_pattern", 32'(gbits[5:0]), 32'(6'b010101));
    run(20);
    chk("idle_after_six", 32'(bz), 0);
    chk("wbursts_six", wbursts, 3);
    chk("rbursts_six", rbursts, 3);

    // write only with known data
    wr_data = 16'h1000;
    wr_req = 1'b1;
    wait_grant();
    wr_req = 1'b0;
    run(15);
    chk("cmd_wr_1000", 32'(cmdwr_word), 32'(16'h1000));
    chk("wbursts_t2", wbursts, 4);

    // one-cycle read pulse still yields a full burst
    chk("idle_before_pulse", 32'(bz), 0);
    rbase = 16'h5500;
    r0 = rbursts;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    run(20);
    chk("rbursts_pulse", rbursts, r0 + 1);

    // asynchronous reset in the middle of a write
    wr_data = 16'h3000;
    wr_req = 1'b1;
    wait_grant();
    wr_req = 1'b0;
    n = 0;
    while (wacks < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("third_ack_seen", wacks, 3);
    chk("oe_before_rst", 32'(oe), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 32'(oe), 0);
    chk("rst_mid_ctrl", 32'({wg, wa, rg, rv, cw, cr, oe, bz}), 0);
    chk("rst_mid_dq_out", 32'(dqo), 0);
    model_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    rbase = 16'h7700;
    run(2);
    rst_n = 1'b1;
    wait_grant();
    chk("rst_read_prio", 32'(rg), 1);
    wr_req = 1'b0; rd_req = 1'b0;
    run(20);
    chk("idle_after_rst", 32'(bz), 0);

    // CAS latency 3 instance
    rst_n = 1'b0;
    sel3 = 1'b1;
    cas = 3;
    model_reset();
    rbase = 16'hA5A0;
    run(2);
    rst_n = 1'b1;
    r0 = rbursts;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    run(20);
    chk("rbursts_cas3", rbursts, r0 + 1);
    chk("last_word_cas3", 32'(rdd), 32'(16'hA5A7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
